// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file with scoreboard.
// Holds the default geometry, the register-count derivation and the
// index of the hard-wired zero register.
package rf_pkg;

  // Default register width and index width.
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  // Default port counts (read ports 1..4, write ports 1..2).
  localparam int NUM_RD_DEF = 2;
  localparam int NUM_WR_DEF = 2;

  // Architectural x0: reads as zero, ignores writes, never busy.
  localparam int ZERO_REG = 0;

  // Number of registers addressable by an index of the given width.
  function automatic int num_regs(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking for the register file.
// An issue reserves a destination (sets busy); any write to a register
// retires it (clears busy). When an issue and a write hit the same
// register in one cycle the issue is the newer producer, so busy stays
// set. Register 0 is never busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_WR     = NUM_WR_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  output logic [num_regs(ADDR_WIDTH)-1:0] busy_vec
);

  localparam int NUM_REGS = num_regs(ADDR_WIDTH);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next busy state: clears from retiring writes first, then the issue
  // set so a same-cycle issue overrides a same-cycle retire.
  always_comb begin
    // NOTE: busy_d takes its full default before any conditional update,
    // so every path assigns it and no latch can be inferred.
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) begin
        busy_d[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (iss_en) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Busy state register; cleared asynchronously so issues presented
  // while reset is held are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of evaluation order.
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with integrated scoreboard.
// NUM_RD combinational read ports, NUM_WR synchronous write ports (the
// highest-index port wins on an address collision) and per-register busy
// tracking for RAW hazard detection in decode.
//
// Build option REGFILE_BYPASS_EN:
//   defined   - a same-cycle write to a read port's (nonzero) index is
//               forwarded onto rd_data and that port's rd_busy reads 0.
//   undefined - rd_data shows array contents only, and a same-cycle write
//               match keeps rd_busy high so decode waits one more cycle.
// While rst_n is low all read outputs are 0 and no forwarding occurs.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_RD     = NUM_RD_DEF,
  parameter int NUM_WR     = NUM_WR_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  output logic [num_regs(ADDR_WIDTH)-1:0] busy_vec
);

  localparam int NUM_REGS = num_regs(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  // Register array: ascending port order makes the highest-index port's
  // write the last one scheduled, so it wins on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array is reset on purpose: reads must return 0 the moment
    // rst_n falls, which rules out a plain (non-resettable) RAM macro.
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_IDX)) begin
          mem[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WR     (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (busy_vec)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] arr_data;
    logic                  hit;
`ifdef REGFILE_BYPASS_EN
    logic [DATA_WIDTH-1:0] fwd_data;
`endif

    assign ra       = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign arr_data = (ra == ZERO_IDX) ? '0 : mem[ra];

    // Same-cycle write match on this port's index; ascending scan lets
    // the highest matching write port supply the forwarded value.
    always_comb begin
      hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
      fwd_data = '0;
`endif
      for (int w = 0; w < NUM_WR; w++) begin
        if (rst_n && wr_en[w] && (ra != ZERO_IDX) &&
            (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
          hit = 1'b1;
`ifdef REGFILE_BYPASS_EN
          fwd_data = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
      end
    end

`ifdef REGFILE_BYPASS_EN
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = hit ? fwd_data : arr_data;
    assign rd_busy[p] = hit ? 1'b0 : busy_vec[ra];
`else
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = arr_data;
    assign rd_busy[p] = busy_vec[ra] | hit;
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed cases for register 0,
// write collisions, scoreboard priority, forwarding and asynchronous
// reset, then randomized traffic against an array-based reference model.
// A second instance (NUM_RD=4, NUM_WR=1, ADDR_WIDTH=4) checks wide reads.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance: defaults (32-bit, 32 regs, 2 read, 2 write).
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [31:0] busy_vec;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  // Wide-read instance.
  logic [15:0]  rd_addr4;
  logic [127:0] rd_data4;
  logic [3:0]   rd_busy4;
  logic [0:0]   wr_en4;
  logic [3:0]   wr_addr4;
  logic [31:0]  wr_data4;
  logic         iss_en4;
  logic [3:0]   iss_addr4;
  logic [15:0]  busy_vec4;

  regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD(4), .NUM_WR(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .rd_busy(rd_busy4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .iss_en(iss_en4), .iss_addr(iss_addr4), .busy_vec(busy_vec4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: register contents and busy flags as plain arrays.
  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  // Apply the rules of one clock edge to the model.
  function automatic void model_commit();
    for (int w = 0; w < 2; w++) begin
      logic [4:0] a;
      a = wr_addr[w*5 +: 5];
      if (wr_en[w]) begin
        if (a != 0) m_mem[a] = wr_data[w*32 +: 32];
        m_busy[a] = 1'b0;
      end
    end
    if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
  endfunction

  // Expected read-port outputs for index a given the current write inputs.
  function automatic void model_read(input logic [4:0] a, output logic [31:0] d, output logic b);
    logic        hit;
    logic [31:0] fwd;
    hit = 1'b0;
    fwd = '0;
    for (int w = 0; w < 2; w++) begin
      if (wr_en[w] && a != 0 && wr_addr[w*5 +: 5] == a) begin
        hit = 1'b1;
        fwd = wr_data[w*32 +: 32];
      end
    end
`ifdef REGFILE_BYPASS_EN
    d = hit ? fwd : m_mem[a];
    b = hit ? 1'b0 : m_busy[a];
`else
    d = m_mem[a];
    b = m_busy[a] | hit;
`endif
  endfunction

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    logic [31:0] d;
    logic        b;
    for (int p = 0; p < 2; p++) begin
      model_read(rd_addr[p*5 +: 5], d, b);
      check($sformatf("%s rd_data%0d", tag, p), rd_data[p*32 +: 32], d);
      check($sformatf("%s rd_busy%0d", tag, p), rd_busy[p], b);
    end
    check($sformatf("%s busy_vec", tag), busy_vec, model_busy_vec());
  endtask

  // Inputs are driven just after a falling edge; check, then clock once.
  task automatic cycle(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  initial begin
    logic [31:0] e;
    rst_n = 1'b0;
    rd_addr = '0; idle();
    rd_addr4 = '0; wr_en4 = '0; wr_addr4 = '0; wr_data4 = '0;
    iss_en4 = 1'b0; iss_addr4 = '0;
    model_reset();

    // Initial reset state.
    rd_addr = {5'd2, 5'd1};
    #3;
    check("reset rd_data", rd_data, 64'h0);
    check("reset rd_busy", rd_busy, 2'b00);
    check("reset busy_vec", busy_vec, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Wide-read instance: sequential writes of 0x10..0x1F.
    for (int i = 0; i < 16; i++) begin
      wr_en4 = 1'b1; wr_addr4 = 4'(i); wr_data4 = 32'h10 + 32'(i);
      @(negedge clk);
    end
    wr_en4 = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int g = 0; g < 4; g++) begin
        for (int p = 0; p < 4; p++) begin
          rd_addr4[p*4 +: 4] = (pass == 0) ? 4'(g*4 + p) : 4'(15 - g*4 - p);
        end
        #1;
        for (int p = 0; p < 4; p++) begin
          e = (rd_addr4[p*4 +: 4] == 0) ? 32'h0 : 32'h10 + 32'(rd_addr4[p*4 +: 4]);
          check($sformatf("wide rd%0d x%0d", p, rd_addr4[p*4 +: 4]), rd_data4[p*32 +: 32], e);
        end
        @(negedge clk);
      end
    end

    // Register 0: write and issue are both no-ops.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h1234};
    iss_en = 1'b1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    cycle("x0 wr");
    idle();
    #1;
    check("x0 read", rd_data[31:0], 32'h0);
    check("x0 busy", busy_vec[0], 1'b0);
    cycle("x0 after");

    // Both write ports to x7: port 1 wins.
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h5555, 32'hAAAA};
    rd_addr = {5'd0, 5'd7};
    cycle("x7 wr");
    idle();
    #1;
    check("x7 collision", rd_data[31:0], 32'h5555);
    cycle("x7 after");

    // Scoreboard set / clear / simultaneous issue+write.
    iss_en = 1'b1; iss_addr = 5'd3; rd_addr = {5'd3, 5'd3};
    cycle("x3 iss");
    idle();
    #1 check("x3 busy set", busy_vec[3], 1'b1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h42};
    cycle("x3 wr");
    idle();
    #1 check("x3 busy clr", busy_vec[3], 1'b0);
    iss_en = 1'b1; iss_addr = 5'd3;
    wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h42, 32'h0};
    cycle("x3 iss+wr");
    idle();
    #1;
    check("x3 busy held", busy_vec[3], 1'b1);
    check("x3 data", rd_data[31:0], 32'h42);
    cycle("x3 after");

    // Write to busy x9 while reading it.
    iss_en = 1'b1; iss_addr = 5'd9;
    cycle("x9 iss");
    idle();
    rd_addr = {5'd0, 5'd9};
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x9 fwd data", rd_data[31:0], 32'h99);
    check("x9 fwd busy", rd_busy[0], 1'b0);
`else
    check("x9 nofwd busy", rd_busy[0], 1'b1);
`endif
    cycle("x9 wr");
    idle();
    #1;
    check("x9 next data", rd_data[31:0], 32'h99);
    check("x9 next busy", rd_busy[0], 1'b0);
    cycle("x9 after");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wr_en   = 2'($urandom);
      wr_addr = 10'($urandom);
      wr_data = {$urandom, $urandom};
      iss_en  = ($urandom_range(0, 3) == 0);
      iss_addr = 5'($urandom);
      for (int p = 0; p < 2; p++) begin
        rd_addr[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_addr[($urandom_range(0, 1))*5 +: 5]
                                                        : 5'($urandom);
      end
      cycle($sformatf("rand%0d", n));
    end
    idle();

    // Asynchronous reset mid-run, with a write/issue pending in that cycle.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    rd_addr = {5'd11, 5'd5};
    cycle("x5 wr");
    idle();
    iss_en = 1'b1; iss_addr = 5'd11;
    cycle("x11 iss");
    idle();
    #1;
    check("pre-rst x5", rd_data[31:0], 32'hDEADBEEF);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h77};
    iss_en = 1'b1; iss_addr = 5'd5;
    #1 rst_n = 1'b0;
    #1;
    check("async rst rd_data", rd_data, 64'h0);
    check("async rst rd_busy", rd_busy, 2'b00);
    check("async rst busy_vec", busy_vec, 32'h0);
    @(posedge clk);
    #1;
    check("held rst rd_data", rd_data, 64'h0);
    check("held rst busy_vec", busy_vec, 32'h0);
    @(negedge clk);
    idle();
    model_reset();
    rst_n = 1'b1;
    cycle("post rst");
    cycle("post rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
